// File: rtl/stream_mux_rr_pkg.sv
// Shared definitions for the streaming N-to-1 multiplexer: mode encodings
// and the width derivation used for channel indices.
package stream_mux_rr_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Channel index width; a single channel pair still needs one bit.
    function automatic int cw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Purely combinational round-robin priority search: first requester at or
// above ptr, wrapping from N-1 back to 0.
module rr_arbiter
    import stream_mux_rr_pkg::*;
#(
    parameter  int N  = 4,
    localparam int CW = cw_of(N)
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] ptr,
    output logic          gnt_valid,
    output logic [CW-1:0] gnt_idx
);

    // Requests rotated so that bit k is channel (ptr + k) mod N.
    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] req_shift;
    logic [N-1:0]   req_rot;
    int             idx_sum;

    assign req_dbl   = {req, req};
    assign req_shift = req_dbl >> ptr;
    assign req_rot   = req_shift[N-1:0];

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx_sum   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                idx_sum = int'(ptr) + k;
                if (idx_sum >= N) begin
                    idx_sum = idx_sum - N;
                end
                gnt_valid = 1'b1;
                gnt_idx   = idx_sum[CW-1:0];
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 stream multiplexer with a registered output stage. Fixed mode
// forwards the channel named by sel; round-robin mode shares the output
// fairly among requesting channels.
module stream_mux_rr
    import stream_mux_rr_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int W  = 8,
    localparam int CW = cw_of(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mode,
    input  logic [CW-1:0]  sel,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic [CW-1:0]  out_ch
);

    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q,  out_data_d;
    logic [CW-1:0] out_ch_q,    out_ch_d;
    logic [CW-1:0] ptr_q,       ptr_d;

    logic          load;
    logic          rr_valid;
    logic [CW-1:0] rr_idx;
    logic          gnt_valid;
    logic [CW-1:0] gnt_idx;
    logic [W-1:0]  gnt_data;

    rr_arbiter #(
        .N (N)
    ) u_arb (
        .req       (in_valid),
        .ptr       (ptr_q),
        .gnt_valid (rr_valid),
        .gnt_idx   (rr_idx)
    );

    // The output register can take a new word when empty or being drained.
    assign load = !out_valid_q || out_ready;

    // Grant decision: arbiter result in RR mode, sel in fixed mode. A sel
    // beyond N-1 matches no channel, so it never grants.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        if (mode == MODE_RR) begin
            gnt_valid = rr_valid;
            gnt_idx   = rr_idx;
        end else begin
            for (int i = 0; i < N; i++) begin
                if ((sel == CW'(i)) && in_valid[i]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = CW'(i);
                end
            end
        end
    end

    // Ready goes only to the granted channel, and only when a load can happen.
    always_comb begin
        in_ready = '0;
        gnt_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_idx == CW'(i)) begin
                in_ready[i] = gnt_valid && load;
                gnt_data    = in_data[i*W +: W];
            end
        end
    end

    // Next state: load the granted word, or drop valid when nothing is
    // granted; the pointer advances past the winner only on RR transfers.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = gnt_valid;
            if (gnt_valid) begin
                out_data_d = gnt_data;
                out_ch_d   = gnt_idx;
                if (mode == MODE_RR) begin
                    ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + CW'(1);
                end
            end
        end
    end

    // Output register and RR pointer; reset discards any held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Randomised scoreboard bench for stream_mux_rr (N=4) plus a short directed
// sequence on an N=3 instance for the out-of-range select.
module tb_stream_mux_rr;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           mode = 1'b0;
    logic [CW-1:0]  sel = '0;
    logic [N-1:0]   in_valid = '0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   out_data;
    logic [CW-1:0]  out_ch;

    // N=3 instance signals
    logic        mode3 = 1'b0;
    logic [1:0]  sel3 = '0;
    logic [2:0]  iv3 = '0;
    logic [23:0] id3 = '0;
    logic [2:0]  ir3;
    logic        ov3;
    logic        or3 = 1'b1;
    logic [7:0]  od3;
    logic [1:0]  oc3;

    always #5 clk = ~clk;

    stream_mux_rr #(.N(N), .W(W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch)
    );

    stream_mux_rr #(.N(3), .W(8)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode3),
        .sel       (sel3),
        .in_valid  (iv3),
        .in_data   (id3),
        .in_ready  (ir3),
        .out_valid (ov3),
        .out_ready (or3),
        .out_data  (od3),
        .out_ch    (oc3)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] data;
        int           ch;
    } exp_t;

    exp_t q[$];

    // Reference model state
    int           m_ptr = 0;
    bit           m_ov  = 1'b0;
    bit           pend[N];
    logic [W-1:0] pend_data[N];

    // Stimulus knobs
    int           vprob = 50;
    int           rprob = 50;
    int           mode_pol = 1;
    int           fixed_sel = 0;
    logic [N-1:0] vmask = '1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Grant from the rules: RR takes the first valid channel counting up
    // from ptr with wrap; fixed takes sel if it names a valid channel.
    function automatic int model_grant(input bit md, input int s, input logic [N-1:0] v, input int p);
        if (md) begin
            for (int k = 0; k < N; k++) begin
                if (v[(p + k) % N]) return (p + k) % N;
            end
            return -1;
        end
        if (s < N && v[s]) return s;
        return -1;
    endfunction

    // One cycle of stimulus and model update, driven between edges.
    task automatic step(input bit in_reset);
        bit           ld;
        int           g;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        #2;
        rst_n = !in_reset;
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && vmask[i] && ($urandom_range(99) < vprob)) begin
                pend[i]      = 1'b1;
                pend_data[i] = W'($urandom);
            end
            in_valid[i]      = pend[i];
            in_data[i*W +: W] = pend[i] ? pend_data[i] : W'($urandom);
        end
        out_ready = ($urandom_range(99) < rprob);
        case (mode_pol)
            0: begin mode = 1'b0; sel = CW'(fixed_sel); end
            1: mode = 1'b1;
            default: begin
                if ($urandom_range(3) == 0) begin
                    mode = 1'($urandom_range(1));
                    sel  = CW'($urandom_range(N - 1));
                end
            end
        endcase
        #1;
        ld = !m_ov || out_ready;
        g  = model_grant(mode, int'(sel), in_valid, m_ptr);
        exp_rdy = '0;
        if (g >= 0 && ld) exp_rdy[g] = 1'b1;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        if (!in_reset && ld) begin
            if (g >= 0) begin
                q.push_back('{data: pend_data[g], ch: g});
                pend[g] = 1'b0;
                m_ov    = 1'b1;
                if (mode) m_ptr = (g + 1) % N;
            end else begin
                m_ov = 1'b0;
            end
        end
    endtask

    // Monitor: just before each edge, a presented word being consumed is
    // popped from the scoreboard and compared.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=ch%0d/%02h required=none", out_ch, out_data);
                end else begin
                    e = q.pop_front();
                    $display("xfer ch=%0d data=%02h exp_ch=%0d exp_data=%02h", out_ch, out_data, e.ch, e.data);
                    chk("out_data", 32'(out_data), 32'(e.data));
                    chk("out_ch", 32'(out_ch), 32'(e.ch));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            pend_data[i] = '0;
        end

        // Power-on reset
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'd0);
        repeat (3) step(1'b1);

        // RR, all valid, full rate
        vprob = 100; rprob = 100; mode_pol = 1;
        repeat (40) step(1'b0);

        // Fixed sel=2, all valid, full rate
        mode_pol = 0; fixed_sel = 2;
        repeat (20) step(1'b0);

        // RR with random requests and backpressure
        vprob = 50; rprob = 60; mode_pol = 1;
        repeat (300) step(1'b0);

        // Random mode/sel switching
        mode_pol = 2;
        repeat (300) step(1'b0);

        // Sparse requests on channels 1 and 3: drain, then restrict
        vprob = 0; rprob = 100; mode_pol = 1;
        repeat (10) step(1'b0);
        vmask = 4'b1010; vprob = 100; rprob = 100;
        repeat (20) step(1'b0);
        vmask = '1;

        // Mid-stream reset with a word held under backpressure
        vprob = 100; rprob = 0; mode_pol = 1;
        repeat (3) step(1'b0);
        rst_n = 1'b0;
        q.delete();
        m_ov  = 1'b0;
        m_ptr = 0;
        #0.5;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_out_data", 32'(out_data), 32'd0);
        chk("async_rst_out_ch", 32'(out_ch), 32'd0);
        repeat (2) step(1'b1);
        rprob = 100;
        repeat (20) step(1'b0);

        // Drain everything
        vprob = 0; rprob = 100; mode_pol = 1;
        repeat (20) step(1'b0);
        #3;
        chk("drain_empty", 32'(q.size()), 32'd0);
        in_valid = '0;

        // N=3: select 1 loads, then sel=3 never grants and output drains
        @(negedge clk);
        mode3 = 1'b0; sel3 = 2'd1; iv3 = 3'b111;
        id3 = {8'hC3, 8'hB2, 8'hA1}; or3 = 1'b0;
        #1;
        chk("n3_ready_sel1", 32'(ir3), 32'b010);
        @(negedge clk);
        chk("n3_out_valid", 32'(ov3), 32'd1);
        chk("n3_out_data", 32'(od3), 32'hB2);
        chk("n3_out_ch", 32'(oc3), 32'd1);
        chk("n3_backpressure_ready", 32'(ir3), 32'd0);
        sel3 = 2'd3; or3 = 1'b1;
        #1;
        chk("n3_sel3_ready", 32'(ir3), 32'd0);
        @(negedge clk);
        chk("n3_drained_valid", 32'(ov3), 32'd0);
        chk("n3_hold_data", 32'(od3), 32'hB2);
        @(negedge clk);
        chk("n3_still_idle", 32'(ov3), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-to-1 streaming multiplexer with a registered output stage and valid/ready handshakes on every channel. In fixed mode it forwards the channel named by `sel`. In round-robin mode it arbitrates fairly among the requesting channels. It is the general successor to the 2-to-1 combinational mux and sits wherever several producers share one consumer.

## Interface
Parameters:
- `N`, 4, number of input channels (2..16).
- `W`, 8, data width per channel.
- `CW`, derived as $clog2(N) (minimum 1), width of `sel` and `out_ch`; local, not overridable.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mode`  in  1  0 = fixed select, 1 = round-robin.
- `sel`  in  CW  channel index used in fixed mode.
- `in_valid`  in  N  per-channel valid; bit i belongs to channel i.
- `in_data`  in  N*W  packed data; channel i occupies bits [i*W +: W].
- `in_ready`  out  N  per-channel ready; at most one bit set per cycle.
- `out_valid`  out  1  output register holds a word.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  W  registered data.
- `out_ch`  out  CW  index of the channel that supplied `out_data`.

## Operation
- **Load condition:** `load = !out_valid || out_ready`.
- **Grant, fixed mode:** grant = `sel` if `sel < N` and `in_valid[sel]`; otherwise no grant. If `sel >= N` (non-power-of-2 N), there is never a grant.
- **Grant, round-robin mode:** grant = the first channel with `in_valid` set, searching from `ptr` upward and wrapping from N-1 to 0.
- **Ready:** `in_ready[g] = load` for the granted channel g; all other bits are 0. `in_ready` is combinational from `in_valid`, `mode`, `sel`, `ptr`, `out_valid` and `out_ready`. It does not depend on `in_data`.
- **Transfer:** a transfer on channel g occurs when `in_valid[g] && in_ready[g]`. On that edge:
  - `out_data` ← channel g data
  - `out_ch` ← g
  - `out_valid` ← 1
- **Drain:** if `load` holds and no channel is granted, `out_valid` ← 0. `out_data` and `out_ch` hold their last values.
- **Pointer:** `ptr` (CW bits) updates only on a round-robin transfer, to `(g+1) mod N`. Fixed-mode transfers leave `ptr` unchanged.
- **Mode and select changes:** a change of `mode` or `sel` takes effect on the very next grant decision. No flush occurs; a word already in the output register is unaffected.
- **Producer contract:** a producer must hold `in_valid` and `in_data` stable until accepted. A violation is not detected.

## Timing
- **Reset values** (while `rst_n` is low, immediately and asynchronously):
  - `out_valid` = 0, `out_data` = 0, `out_ch` = 0, `ptr` = 0
  - `in_ready` = 0 for every channel except the one that would be granted. Since `load` = 1 when `out_valid` = 0, `in_ready` follows `in_valid`, `mode` and `sel` combinationally even during reset.
  - Reset asserted mid-transfer discards the output word. No transfer is recorded while `rst_n` is low.
- **Latency:** one cycle, from the accepting edge to `out_valid`/`out_data` visible.
- **Throughput:** one word per cycle when `out_ready` is held high.
- **Simultaneous consume and load:** when `out_ready` = 1 with a word present, the next word loads on the same edge, so `out_valid` stays 1 with no bubble.
- **Backpressure:** when `out_ready` = 0 with `out_valid` = 1, all `in_ready` bits are 0 and the output holds steady.
- **Fairness:** with all N channels valid continuously in round-robin mode, each channel is granted exactly once per N consecutive transfers.

## Structure
- **Shared package/header:** mode encodings (`MODE_FIXED` = 0, `MODE_RR` = 1) and the CW derivation function.
- **Sub-module `rr_arbiter`:**
  - Parameter: N.
  - Inputs: `req[N]`, `ptr[CW]`.
  - Outputs: `gnt_valid`, `gnt_idx[CW]`.
  - Purely combinational priority search.
  - The top level holds `ptr`, the fixed/RR selection, and the output register.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-stream with `out_valid` = 1 → outputs go to 0 immediately without waiting for `clk`; after release, `ptr` = 0 is confirmed by the first RR grant going to channel 0 with all channels valid.
- **Fixed mode, N=4, W=8:** `sel` = 2, `in_valid` = 4'b1111, data 0x10/0x20/0x30/0x40, `out_ready` = 1 → every cycle `out_data` = 0x30, `out_ch` = 2; only `in_ready[2]` is high.
- **Round-robin, all valid, `out_ready` = 1:** grants cycle through channels 0, 1, 2, 3, 0, ... with `out_ch` following one cycle later and `out_valid` continuously 1.
- **Round-robin, sparse requests:** `in_valid` = 4'b1010 with `ptr` = 0 → grant 1, then 3, then 1; `ptr` after each transfer is 2, 0, 2.
- **Backpressure:** `out_ready` = 0 for 3 cycles with a word held → `out_data` stable, `in_ready` = 0; on release, the held word is consumed and the next loads on the same edge with no bubble.
- **Mode switch and invalid select:** switch `mode` 1→0 with `sel` = 3 while `ptr` = 1 → the next grant goes to channel 3 and `ptr` stays 1. For N=3, `sel` = 3 → no grant, and `out_valid` drops after the held word drains.
